uart_rx_fifo: RTL

Parametrised UART receiver, next generation of the single-buffer receiver on the APB UART peripheral side.
- Adds configurable oversampling, 3-sample majority voting, false-start rejection and break detection.
- Adds a parametrised RX FIFO carrying per-character error flags, plus RTS flow control driven by a FIFO level threshold.
- Sits between the external rx pin and the APB register block, which pops characters through a show-ahead read port.

---
 rtl/uart_pkg.sv | 60 ++++++
 rtl/uart_sync_fifo.sv | 78 +++++++
 rtl/uart_rx_fifo.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : uart_pkg
//  Description : Shared types, constants and helpers for the UART receiver
//                and its RX FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receiver frame states
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    // One received character as stored in the RX FIFO
    typedef struct packed {
        logic       frame_err;
        logic       parity_err;
        logic [7:0] data;
    } rx_entry_t;

    localparam int ENTRY_W = $bits(rx_entry_t);

    // data_bit_num encodings
    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    // Clocks per oversampling tick; never below one so the tick stays defined
    function automatic int calc_baud_div(input int clk_freq,
                                         input int baud_rate,
                                         input int oversample);
        int div;
        div = clk_freq / (baud_rate * oversample);
        if (div < 1) begin
            div = 1;
        end
        return div;
    endfunction

    // Index of the last data bit for a given data_bit_num code
    function automatic logic [2:0] last_data_idx(input logic [1:0] dbn);
        logic [2:0] idx;
        case (dbn)
            DBITS_5: idx = 3'd4;
            DBITS_6: idx = 3'd5;
            DBITS_7: idx = 3'd6;
            DBITS_8: idx = 3'd7;
            default: idx = 3'd7;
        endcase
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync_fifo
//  Description : Single-clock show-ahead FIFO with registered empty/full/level.
//                A push into a full FIFO is accepted only alongside a pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_next;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);

    // Head entry is visible while not empty, zero otherwise
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Occupancy after this edge's push/pop
    always_comb begin
        level_next = level;
        if (do_push && !do_pop) begin
            level_next = level + 1'b1;
        end else if (!do_push && do_pop) begin
            level_next = level - 1'b1;
        end
    end

    // Pointers (power-of-two depth wraps naturally) and registered status
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level_next;
            empty <= (level_next == '0);
            full  <= (level_next == LW'(DEPTH));
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Oversampling UART receiver with majority voting, false-start
//                rejection, break detection, RX FIFO with per-character error
//                flags, sticky overrun and RTS flow control.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ      = 50000000,
    parameter int BAUD_RATE     = 115200,
    parameter int OVERSAMPLE    = 16,
    parameter int FIFO_DEPTH    = 16,
    parameter int RTS_THRESHOLD = 12
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [1:0]                    data_bit_num,
    input  logic                          stop_bit_num,
    input  logic                          parity_en,
    input  logic                          parity_type,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rd_parity_err,
    output logic                          rd_frame_err,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overrun,
    input  logic                          overrun_clr,
    output logic                          break_det,
    output logic                          rts_n
);

    localparam int DIV   = calc_baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SC_W  = $clog2(OVERSAMPLE);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    // Sample-tick positions within one bit
    localparam logic [SC_W-1:0] SMP_FIRST = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0] SMP_MID   = SC_W'(OVERSAMPLE / 2);
    localparam logic [SC_W-1:0] SMP_LAST  = SC_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SC_W-1:0] BIT_END   = SC_W'(OVERSAMPLE - 1);

    // Synchroniser and edge history
    logic rx_meta;
    logic rx_sync;
    logic rx_prev;

    // Tick generator
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             start_edge;

    // Receiver FSM state
    rx_state_e        state;
    logic [SC_W-1:0]  smp_cnt;
    logic             smp_a;
    logic             smp_b;
    logic             vote;
    logic [2:0]       bit_idx;
    logic             stop_idx;
    logic [1:0]       cfg_data_bits;
    logic             cfg_stop_bits;
    logic             cfg_parity_en;
    logic             cfg_parity_type;
    logic [7:0]       shift_data;
    logic             parity_bit;
    logic             parity_err;
    logic             frame_err;
    logic             first_stop;
    logic             first_stop_now;
    logic             is_break;
    logic             armed;
    logic             push;
    logic             break_pulse;
    rx_entry_t        push_entry;

    // FIFO interface
    logic [ENTRY_W-1:0] push_word;
    logic [ENTRY_W-1:0] head_word;
    rx_entry_t          head;
    logic               drop;

    // Two-stage synchroniser plus one history stage for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_edge = (state == RX_IDLE) && armed && rx_prev && !rx_sync;
    assign tick       = (div_cnt == DIV_W'(DIV - 1));

    // Oversampling tick counter, re-phased to each detected start edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (start_edge || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // 2-of-3 vote over the two stored samples and the current one
    assign vote = (smp_a & smp_b) | (smp_a & rx_sync) | (smp_b & rx_sync);

    // A break needs the first stop bit low; in the first stop bit it is the vote itself
    assign first_stop_now = (stop_idx == 1'b0) ? vote : first_stop;
    assign is_break       = (shift_data == 8'h00) &&
                            (!cfg_parity_en || !parity_bit) &&
                            !first_stop_now;

    // Receiver frame sequencer with registered push / break outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= RX_IDLE;
            smp_cnt         <= '0;
            smp_a           <= 1'b1;
            smp_b           <= 1'b1;
            bit_idx         <= '0;
            stop_idx        <= 1'b0;
            cfg_data_bits   <= DBITS_8;
            cfg_stop_bits   <= 1'b0;
            cfg_parity_en   <= 1'b0;
            cfg_parity_type <= 1'b0;
            shift_data      <= '0;
            parity_bit      <= 1'b0;
            parity_err      <= 1'b0;
            frame_err       <= 1'b0;
            first_stop      <= 1'b1;
            armed           <= 1'b1;
            push            <= 1'b0;
            break_pulse     <= 1'b0;
            push_entry      <= '0;
        end else begin
            push        <= 1'b0;
            break_pulse <= 1'b0;
            if (state == RX_IDLE) begin
                // After a break the line must be seen high before re-arming
                if (rx_sync) begin
                    armed <= 1'b1;
                end
                if (start_edge) begin
                    state           <= RX_START;
                    smp_cnt         <= '0;
                    bit_idx         <= '0;
                    stop_idx        <= 1'b0;
                    cfg_data_bits   <= data_bit_num;
                    cfg_stop_bits   <= stop_bit_num;
                    cfg_parity_en   <= parity_en;
                    cfg_parity_type <= parity_type;
                    shift_data      <= '0;
                    parity_bit      <= 1'b0;
                    parity_err      <= 1'b0;
                    frame_err       <= 1'b0;
                    first_stop      <= 1'b1;
                end
            end else if (tick) begin
                smp_cnt <= (smp_cnt == BIT_END) ? '0 : smp_cnt + 1'b1;
                if (smp_cnt == SMP_FIRST) begin
                    smp_a <= rx_sync;
                end
                if (smp_cnt == SMP_MID) begin
                    smp_b <= rx_sync;
                end
                case (state)
                    RX_START: begin
                        if (smp_cnt == SMP_LAST && vote) begin
                            state <= RX_IDLE;
                        end else if (smp_cnt == BIT_END) begin
                            state <= RX_DATA;
                        end
                    end
                    RX_DATA: begin
                        if (smp_cnt == SMP_LAST) begin
                            shift_data[bit_idx] <= vote;
                        end
                        if (smp_cnt == BIT_END) begin
                            if (bit_idx == last_data_idx(cfg_data_bits)) begin
                                bit_idx <= '0;
                                state   <= cfg_parity_en ? RX_PARITY : RX_STOP;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end
                    end
                    RX_PARITY: begin
                        if (smp_cnt == SMP_LAST) begin
                            parity_bit <= vote;
                            // Even: total ones must be even; odd: must be odd
                            parity_err <= (((^shift_data) ^ vote) == cfg_parity_type);
                        end
                        if (smp_cnt == BIT_END) begin
                            state <= RX_STOP;
                        end
                    end
                    RX_STOP: begin
                        if (smp_cnt == SMP_LAST) begin
                            if (stop_idx == cfg_stop_bits) begin
                                // Last stop bit decided: push now, do not wait for bit end
                                push       <= 1'b1;
                                state      <= RX_IDLE;
                                push_entry <= '{frame_err:  frame_err | ~vote,
                                                parity_err: parity_err,
                                                data:       shift_data};
                                if (is_break) begin
                                    break_pulse <= 1'b1;
                                    armed       <= 1'b0;
                                end
                            end else begin
                                first_stop <= vote;
                                frame_err  <= frame_err | ~vote;
                            end
                        end
                        if (smp_cnt == BIT_END) begin
                            stop_idx <= 1'b1;
                        end
                    end
                    default: begin
                        state <= RX_IDLE;
                    end
                endcase
            end
        end
    end

    assign push_word = push_entry;
    assign drop      = push && full && !rd_en;

    uart_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (push),
        .wr_data (push_word),
        .rd_en   (rd_en),
        .rd_data (head_word),
        .empty   (empty),
        .full    (full),
        .level   (level)
    );

    assign head          = rx_entry_t'(head_word);
    assign rd_data       = head.data;
    assign rd_parity_err = head.parity_err;
    assign rd_frame_err  = head.frame_err;
    assign break_det     = break_pulse;

    // Sticky overrun: a new drop takes priority over a clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

    // Flow control follows the registered level one clock later
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rts_n <= 1'b0;
        end else begin
            rts_n <= (level >= LVL_W'(RTS_THRESHOLD));
        end
    end

endmodule
`default_nettype wire
